// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states, counter width.
package alu_req_arbiter_pkg;

   localparam int CNT_W_DEF = 16;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_MOD  = 4'b0100;
   localparam logic [3:0] OP_SHL  = 4'b0101;
   localparam logic [3:0] OP_SHR  = 4'b0110;
   localparam logic [3:0] OP_ROL  = 4'b0111;
   localparam logic [3:0] OP_ROR  = 4'b1000;
   localparam logic [3:0] OP_AND  = 4'b1001;
   localparam logic [3:0] OP_OR   = 4'b1010;
   localparam logic [3:0] OP_XOR  = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_NAND = 4'b1101;
   localparam logic [3:0] OP_GT   = 4'b1110;
   localparam logic [3:0] OP_EQ   = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   function automatic logic is_div_zero(input logic [3:0] sel, input logic [7:0] b);
      return (sel == OP_DIV) && (b == 8'd0);
   endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module alu_rr_pick (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic grant,
   output logic grant_valid
);

   always_comb begin
      grant_valid = valid0 | valid1;
      grant       = valid1;
      if (valid0 && valid1) begin
         grant = ~last_grant;
      end
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// Arbitrates two requesters onto one external 8-bit ALU and returns one response per op.
// Optional divide-by-zero guard: define ALU_DIVZERO_GUARD_EN.
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | waiting; combinational grant, accepts one request
// ST_EXEC | latched operands on the ALU, result captured this cycle
// ST_RESP | rsp_valid high, fields frozen until rsp_ready
module alu_req_arbiter
   import alu_req_arbiter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [7:0]       req0_a,
   input  logic [7:0]       req0_b,
   input  logic [3:0]       req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [7:0]       req1_a,
   input  logic [7:0]       req1_b,
   input  logic [3:0]       req1_sel,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [3:0]       alu_sel,
   input  logic [7:0]       alu_out,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [7:0]       rsp_data,
   output logic             rsp_carry,
   output logic             rsp_err,
   output logic [CNT_W-1:0] ops_done
);

   arb_state_t state;
   arb_state_t state_nxt;
   logic       last_grant;
   logic       grant;
   logic       grant_valid;
   logic       accept;

   alu_rr_pick u_pick (
      .valid0      (req0_valid),
      .valid1      (req1_valid),
      .last_grant  (last_grant),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Ready is masked during reset so nothing is accepted by a cycle that is being discarded.
   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp_valid  = 1'b0;
      accept     = 1'b0;
      case (state)
         ST_IDLE: begin
            req0_ready = !rst && grant_valid && !grant;
            req1_ready = !rst && grant_valid && grant;
            accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
            if (accept) begin
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         alu_a      <= 8'd0;
         alu_b      <= 8'd0;
         alu_sel    <= 4'd0;
         rsp_id     <= 1'b0;
         rsp_data   <= 8'd0;
         rsp_carry  <= 1'b0;
         ops_done   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  alu_a      <= grant ? req1_a   : req0_a;
                  alu_b      <= grant ? req1_b   : req0_b;
                  alu_sel    <= grant ? req1_sel : req0_sel;
                  rsp_id     <= grant;
                  last_grant <= grant;
               end
            end
            ST_EXEC: begin
               rsp_data  <= alu_out;
               rsp_carry <= alu_carry;
`ifdef ALU_DIVZERO_GUARD_EN
               if (is_div_zero(alu_sel, alu_b)) begin
                  rsp_data  <= 8'hFF;
                  rsp_carry <= 1'b0;
               end
`endif
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  ops_done <= ops_done + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_DIVZERO_GUARD_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_err <= 1'b0;
      end else if (state == ST_EXEC) begin
         rsp_err <= is_div_zero(alu_sel, alu_b);
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

endmodule
